// File: rtl/addr_gen_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : ntt_addr_pkg
// Brief  : Shared types, default widths and lane-address helper for the
//          sequenced NTT/INTT butterfly address generator.
// Rev    : 1.0  initial release
// ============================================================================
package ntt_addr_pkg;

    localparam int ADDR_W    = 10;
    localparam int LANES     = 8;
    localparam int CNT_W     = ADDR_W - $clog2(LANES);
    localparam int STG_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Natural (non-reversed) address of one lane for a given beat.
    function automatic int unsigned lane_addr(
        input logic        ntt,
        input int unsigned cnt,
        input int unsigned lane,
        input int unsigned lanes,
        input int unsigned half_n
    );
        int unsigned bfu;
        bfu = lanes / 2;
        if (!ntt)
            return cnt * lanes + lane;
        if (lane < bfu)
            return cnt * bfu + lane;
        return cnt * bfu + half_n + (lane - bfu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr_gen_seq_if.sv
`default_nettype none
// ============================================================================
// Module : addr_gen_seq_if
// Brief  : Control and address-beat bundle between the multiplier controller,
//          the address generator and the RAM bank address muxes.
// Rev    : 1.0  initial release
// ============================================================================
interface addr_gen_seq_if
    import ntt_addr_pkg::*;
#(
    parameter int N_LOG   = ADDR_W,
    parameter int BFU_NUM = LANES / 2,
    parameter int STG_W   = STG_W_DEF
);
    localparam int C_LANES = 2 * BFU_NUM;
    localparam int C_CNT_W = N_LOG - $clog2(C_LANES);

    logic                       start;
    logic                       ntt_flag;
    logic                       rev;
    logic [STG_W-1:0]           num_stages;
    logic                       abort;
    logic                       addr_ready;
    logic                       addr_valid;
    logic [C_LANES*N_LOG-1:0]   addr_bus;
    logic [STG_W-1:0]           stage_idx;
    logic [C_CNT_W-1:0]         beat_cnt;
    logic                       last_beat;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, ntt_flag, rev, num_stages, abort, addr_ready,
        output addr_valid, addr_bus, stage_idx, beat_cnt, last_beat, busy, done
    );

    modport slave (
        output start, ntt_flag, rev, num_stages, abort, addr_ready,
        input  addr_valid, addr_bus, stage_idx, beat_cnt, last_beat, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/addr_gen_seq_bit_rev.sv
`default_nettype none
// ============================================================================
// Module : bit_rev
// Brief  : Parametrised combinational bit reverser.
// Rev    : 1.0  initial release
// ============================================================================
module bit_rev
    import ntt_addr_pkg::*;
#(
    parameter int DATA_WIDTH = ADDR_W
) (
    input  wire logic [DATA_WIDTH-1:0] data_i,
    output logic      [DATA_WIDTH-1:0] data_o
);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
        assign data_o[i] = data_i[DATA_WIDTH-1-i];
    end

endmodule
`default_nettype wire

// File: rtl/addr_gen_seq.sv
`default_nettype none
// ============================================================================
// Module : addr_gen_seq
// Brief  : Self-sequencing butterfly address generator; walks every stage and
//          group of an NTT/INTT pass, emitting 2*BFU_NUM addresses per beat.
// Rev    : 1.0  initial release
// ============================================================================
module addr_gen_seq
    import ntt_addr_pkg::*;
#(
    parameter int N_LOG   = ADDR_W,
    parameter int BFU_NUM = LANES / 2,
    parameter int STG_W   = STG_W_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    addr_gen_seq_if.master  agi
);

    localparam int C_ADDR_W = N_LOG;
    localparam int C_LANES  = 2 * BFU_NUM;
    localparam int C_CNT_W  = N_LOG - $clog2(C_LANES);
    localparam int C_BUS_W  = C_LANES * C_ADDR_W;
    localparam int C_HALF_N = 2 ** (N_LOG - 1);
    localparam logic [STG_W-1:0] C_NLOG = STG_W'(N_LOG);

    state_e               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]     stage_q, stage_d;
    logic [STG_W-1:0]     nst_q, nst_d;
    logic                 ntt_q, ntt_d;
    logic                 rev_q, rev_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [C_BUS_W-1:0]   bus_q, bus_d;
    logic [C_BUS_W-1:0]   w_bus;
    logic                 w_xfer;
    logic                 w_final;
    logic                 w_start_ok;

    assign w_xfer     = valid_q && agi.addr_ready;
    assign w_final    = w_xfer && (&cnt_q) && (stage_q == nst_q - STG_W'(1));
    assign w_start_ok = agi.start && (agi.num_stages != '0) && (agi.num_stages <= C_NLOG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            nst_q   <= '0;
            ntt_q   <= 1'b0;
            rev_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            nst_q   <= nst_d;
            ntt_q   <= ntt_d;
            rev_q   <= rev_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        nst_d   = nst_q;
        ntt_d   = ntt_q;
        rev_d   = rev_q;
        if (agi.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            stage_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        state_d = ST_RUN;
                        ntt_d   = agi.ntt_flag;
                        rev_d   = agi.rev;
                        nst_d   = agi.num_stages;
                        cnt_d   = '0;
                        stage_d = '0;
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        cnt_d = cnt_q + C_CNT_W'(1);
                        if (&cnt_q)
                            stage_d = stage_q + STG_W'(1);
                        if (w_final)
                            state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Lane addresses are built from next-state values so the bus register
    // already holds the beat that becomes valid, and simply re-loads itself
    // while the consumer stalls.
    for (genvar j = 0; j < C_LANES; j++) begin : g_lane
        logic [C_ADDR_W-1:0] w_nat;
        logic [C_ADDR_W-1:0] w_rev;
        assign w_nat = C_ADDR_W'(lane_addr(ntt_d, 32'(cnt_d), j, C_LANES, C_HALF_N));
        bit_rev #(.DATA_WIDTH(C_ADDR_W)) u_bit_rev (
            .data_i (w_nat),
            .data_o (w_rev)
        );
        assign w_bus[j*C_ADDR_W +: C_ADDR_W] = (rev_d && (stage_d == '0)) ? w_rev : w_nat;
    end

    always_comb begin
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
        last_d  = valid_d && (&cnt_d);
        bus_d   = w_bus;
        done_d  = 1'b0;
        if (!agi.abort) begin
            if (state_q == ST_RUN && w_final)
                done_d = 1'b1;
            else if (state_q == ST_IDLE && agi.start && !w_start_ok)
                done_d = 1'b1;
        end
    end

    assign agi.addr_valid = valid_q;
    assign agi.addr_bus   = bus_q;
    assign agi.stage_idx  = stage_q;
    assign agi.beat_cnt   = cnt_q;
    assign agi.last_beat  = last_q;
    assign agi.busy       = busy_q;
    assign agi.done       = done_q;

endmodule
`default_nettype wire
